// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush scheduler for the 5-stage pipeline.
//
// Produces the hold, flush and bubble controls for the PC and the four pipeline
// registers each cycle. It resolves load-use hazards and taken-branch flushes,
// and it sequences the variable-latency data memory through a req/ack handshake
// guarded by a timeout watchdog. It also keeps a saturating count of stall cycles.
//
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset
//   IFID_RS1addr_i/RS2    source registers of the instruction in ID
//   IDEX_MemRead_i/RDaddr load flag and destination of the instruction in EX
//   Branch_taken_i        branch resolved taken in ID
//   EXMEM_MemRead_i/Write memory operation of the instruction in MEM
//   dmem_ack_i            data memory completes the current access
//   PC_stall_o .. MEMWB_bubble_o  pipeline register controls (combinational)
//   dmem_req_o            data memory request (combinational)
//   timeout_o             sticky watchdog error (registered)
//   stall_cnt_o           saturating count of cycles with PC_stall_o=1
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IFID_RS1addr_i,
  input  logic [4:0]       IFID_RS2addr_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RDaddr_i,
  input  logic             Branch_taken_i,
  input  logic             EXMEM_MemRead_i,
  input  logic             EXMEM_MemWrite_i,
  input  logic             dmem_ack_i,
  output logic             PC_stall_o,
  output logic             IFID_stall_o,
  output logic             IFID_flush_o,
  output logic             IDEX_bubble_o,
  output logic             IDEX_stall_o,
  output logic             EXMEM_stall_o,
  output logic             MEMWB_bubble_o,
  output logic             dmem_req_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned WcntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StWait, StError} state_e;

  state_e             state_q, state_d;
  logic [WcntW-1:0]   wcnt_q, wcnt_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic memop;
  logic memstall;
  logic lu;

  assign memop = EXMEM_MemRead_i | EXMEM_MemWrite_i;

  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign lu = IDEX_MemRead_i & (IDEX_RDaddr_i != 5'd0) &
              ((IDEX_RDaddr_i == IFID_RS1addr_i) | (IDEX_RDaddr_i == IFID_RS2addr_i));

  // Memory handshake FSM and watchdog.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    timeout_d  = timeout_q;
    memstall   = 1'b0;
    dmem_req_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (memop) begin
          dmem_req_o = 1'b1;
          if (!dmem_ack_i) begin
            memstall = 1'b1;
            state_d  = StWait;
            wcnt_d   = WcntW'(1);
          end
        end
      end
      StWait: begin
        dmem_req_o = 1'b1;
        if (dmem_ack_i) begin
          // Ack cycle lets the pipeline advance; the next memop is a new instruction.
          state_d = StIdle;
          wcnt_d  = '0;
        end else if (wcnt_q == WcntW'(TIMEOUT)) begin
          memstall  = 1'b1;
          state_d   = StError;
          timeout_d = 1'b1;
        end else begin
          memstall = 1'b1;
          wcnt_d   = wcnt_q + WcntW'(1);
        end
      end
      StError: begin
        // Terminal until reset; a late ack is ignored because no request is open.
        memstall = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (rst_i) begin
      memstall   = 1'b0;
      dmem_req_o = 1'b0;
    end
  end

  // Pipeline register controls. Memory stall freezes everything and overrides
  // load-use and branch handling, which are re-evaluated once the stall lifts.
  always_comb begin
    PC_stall_o     = 1'b0;
    IFID_stall_o   = 1'b0;
    IFID_flush_o   = 1'b0;
    IDEX_bubble_o  = 1'b0;
    IDEX_stall_o   = 1'b0;
    EXMEM_stall_o  = 1'b0;
    MEMWB_bubble_o = 1'b0;

    if (rst_i) begin
      // All controls held low while in reset.
    end else if (memstall) begin
      PC_stall_o     = 1'b1;
      IFID_stall_o   = 1'b1;
      IDEX_stall_o   = 1'b1;
      EXMEM_stall_o  = 1'b1;
      MEMWB_bubble_o = 1'b1;
    end else begin
      PC_stall_o    = lu;
      IFID_stall_o  = lu;
      IDEX_bubble_o = lu;
      // Stall wins over a coincident branch; the branch is seen again next cycle.
      IFID_flush_o  = Branch_taken_i & ~lu;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (PC_stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      wcnt_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign timeout_o   = timeout_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (TIMEOUT=4, CNT_W=4).
module tb_pipe_hazard_ctrl;

  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CNT_W   = 4;

  // Output vector order: {PC_stall, IFID_stall, IFID_flush, IDEX_bubble,
  //                       IDEX_stall, EXMEM_stall, MEMWB_bubble, dmem_req, timeout}
  localparam logic [8:0] OutIdle  = 9'b000000000;
  localparam logic [8:0] OutLu    = 9'b110100000;
  localparam logic [8:0] OutLuReq = 9'b110100010;
  localparam logic [8:0] OutFull  = 9'b110011110;
  localparam logic [8:0] OutErr   = 9'b110011101;
  localparam logic [8:0] OutFlush = 9'b001000000;
  localparam logic [8:0] OutReq   = 9'b000000010;
  localparam logic [8:0] OutTo    = 9'b000000001;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [4:0]       IFID_RS1addr_i, IFID_RS2addr_i, IDEX_RDaddr_i;
  logic             IDEX_MemRead_i, Branch_taken_i;
  logic             EXMEM_MemRead_i, EXMEM_MemWrite_i, dmem_ack_i;
  logic             PC_stall_o, IFID_stall_o, IFID_flush_o, IDEX_bubble_o;
  logic             IDEX_stall_o, EXMEM_stall_o, MEMWB_bubble_o, dmem_req_o, timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [8:0]       outs;

  int errors = 0;
  int checks = 0;

  pipe_hazard_ctrl #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .IFID_RS1addr_i  (IFID_RS1addr_i),
    .IFID_RS2addr_i  (IFID_RS2addr_i),
    .IDEX_MemRead_i  (IDEX_MemRead_i),
    .IDEX_RDaddr_i   (IDEX_RDaddr_i),
    .Branch_taken_i  (Branch_taken_i),
    .EXMEM_MemRead_i (EXMEM_MemRead_i),
    .EXMEM_MemWrite_i(EXMEM_MemWrite_i),
    .dmem_ack_i      (dmem_ack_i),
    .PC_stall_o      (PC_stall_o),
    .IFID_stall_o    (IFID_stall_o),
    .IFID_flush_o    (IFID_flush_o),
    .IDEX_bubble_o   (IDEX_bubble_o),
    .IDEX_stall_o    (IDEX_stall_o),
    .EXMEM_stall_o   (EXMEM_stall_o),
    .MEMWB_bubble_o  (MEMWB_bubble_o),
    .dmem_req_o      (dmem_req_o),
    .timeout_o       (timeout_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  assign outs = {PC_stall_o, IFID_stall_o, IFID_flush_o, IDEX_bubble_o, IDEX_stall_o,
                 EXMEM_stall_o, MEMWB_bubble_o, dmem_req_o, timeout_o};

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    IFID_RS1addr_i   = 5'd0;
    IFID_RS2addr_i   = 5'd0;
    IDEX_MemRead_i   = 1'b0;
    IDEX_RDaddr_i    = 5'd0;
    Branch_taken_i   = 1'b0;
    EXMEM_MemRead_i  = 1'b0;
    EXMEM_MemWrite_i = 1'b0;
    dmem_ack_i       = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 1'b1;
    EXMEM_MemRead_i = 1'b1;
    IDEX_MemRead_i  = 1'b1;
    IDEX_RDaddr_i   = 5'd3;
    IFID_RS1addr_i  = 5'd3;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (outs !== OutIdle) begin
        errors++;
        $display("FAIL reset_outs[%0d]: got %b want %b", i, outs, OutIdle);
      end
      checks++;
      if (stall_cnt_o !== 4'd0) begin
        errors++;
        $display("FAIL reset_cnt[%0d]: got %0d want 0", i, stall_cnt_o);
      end
    end
    rst_i = 1'b0;
    clear_inputs();
    EXMEM_MemRead_i = 1'b1;
    #1;
    checks++;
    if (outs !== OutFull) begin
      errors++;
      $display("FAIL reset_idle_memop: got %b want %b", outs, OutFull);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    IDEX_MemRead_i = 1'b1;
    IDEX_RDaddr_i  = 5'd5;
    IFID_RS2addr_i = 5'd5;
    #1;
    checks++;
    if (outs !== OutLu) begin
      errors++;
      $display("FAIL lu_outs: got %b want %b", outs, OutLu);
    end
    step();
    checks++;
    if (stall_cnt_o !== 4'd1) begin
      errors++;
      $display("FAIL lu_cnt: got %0d want 1", stall_cnt_o);
    end
    IDEX_MemRead_i = 1'b0;
    #1;
    checks++;
    if (outs !== OutIdle) begin
      errors++;
      $display("FAIL lu_clear: got %b want %b", outs, OutIdle);
    end
    // rd = x0 must never stall even though rs1/rs2 also read x0.
    IDEX_MemRead_i = 1'b1;
    IDEX_RDaddr_i  = 5'd0;
    IFID_RS2addr_i = 5'd0;
    #1;
    checks++;
    if (outs !== OutIdle) begin
      errors++;
      $display("FAIL lu_x0: got %b want %b", outs, OutIdle);
    end
    step();
    checks++;
    if (stall_cnt_o !== 4'd1) begin
      errors++;
      $display("FAIL lu_x0_cnt: got %0d want 1", stall_cnt_o);
    end
  endtask

  task automatic test_lu_branch();
    do_reset();
    IDEX_MemRead_i = 1'b1;
    IDEX_RDaddr_i  = 5'd7;
    IFID_RS1addr_i = 5'd7;
    Branch_taken_i = 1'b1;
    #1;
    checks++;
    if (outs !== OutLu) begin
      errors++;
      $display("FAIL lu_branch_stall: got %b want %b", outs, OutLu);
    end
    step();
    IDEX_MemRead_i = 1'b0;
    #1;
    checks++;
    if (outs !== OutFlush) begin
      errors++;
      $display("FAIL lu_branch_flush: got %b want %b", outs, OutFlush);
    end
    step();
    checks++;
    if (stall_cnt_o !== 4'd1) begin
      errors++;
      $display("FAIL lu_branch_cnt: got %0d want 1", stall_cnt_o);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    EXMEM_MemRead_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dmem_ack_i = (i == 3);
      #1;
      checks++;
      if (outs !== ((i < 3) ? OutFull : OutReq)) begin
        errors++;
        $display("FAIL mem_wait[%0d]: got %b want %b", i, outs,
                 (i < 3) ? OutFull : OutReq);
      end
      step();
    end
    checks++;
    if (stall_cnt_o !== 4'd3) begin
      errors++;
      $display("FAIL mem_wait_cnt: got %0d want 3", stall_cnt_o);
    end
    // Back-to-back store with a zero-wait ack: request only, no stall.
    EXMEM_MemRead_i  = 1'b0;
    EXMEM_MemWrite_i = 1'b1;
    dmem_ack_i       = 1'b1;
    #1;
    checks++;
    if (outs !== OutReq) begin
      errors++;
      $display("FAIL mem_zero_wait: got %b want %b", outs, OutReq);
    end
    step();
    clear_inputs();
    #1;
    checks++;
    if (outs !== OutIdle || stall_cnt_o !== 4'd3) begin
      errors++;
      $display("FAIL mem_after: got %b cnt %0d want %b cnt 3", outs, stall_cnt_o, OutIdle);
    end
  endtask

  task automatic test_mem_overlap();
    do_reset();
    EXMEM_MemRead_i = 1'b1;
    IDEX_MemRead_i  = 1'b1;
    IDEX_RDaddr_i   = 5'd9;
    IFID_RS1addr_i  = 5'd9;
    Branch_taken_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (outs !== OutFull) begin
        errors++;
        $display("FAIL overlap_wait[%0d]: got %b want %b", i, outs, OutFull);
      end
      step();
    end
    dmem_ack_i = 1'b1;
    #1;
    checks++;
    if (outs !== OutLuReq) begin
      errors++;
      $display("FAIL overlap_ack: got %b want %b", outs, OutLuReq);
    end
    step();
    EXMEM_MemRead_i = 1'b0;
    dmem_ack_i      = 1'b0;
    #1;
    checks++;
    if (outs !== OutLu) begin
      errors++;
      $display("FAIL overlap_lu: got %b want %b", outs, OutLu);
    end
    step();
    IDEX_MemRead_i = 1'b0;
    #1;
    checks++;
    if (outs !== OutFlush || stall_cnt_o !== 4'd5) begin
      errors++;
      $display("FAIL overlap_flush: got %b cnt %0d want %b cnt 5", outs, stall_cnt_o, OutFlush);
    end
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    EXMEM_MemRead_i = 1'b1;
    // One IDLE cycle plus TIMEOUT WAIT cycles, all fully stalled.
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (outs !== OutFull) begin
        errors++;
        $display("FAIL timeout_wait[%0d]: got %b want %b", i, outs, OutFull);
      end
      step();
    end
    checks++;
    if (outs !== OutErr) begin
      errors++;
      $display("FAIL timeout_err: got %b want %b", outs, OutErr);
    end
    dmem_ack_i = 1'b1;
    #1;
    checks++;
    if (outs !== OutErr) begin
      errors++;
      $display("FAIL timeout_late_ack: got %b want %b", outs, OutErr);
    end
    step();
    clear_inputs();
    // 6 stall cycles counted so far; 14 more push the counter past its maximum.
    for (int i = 0; i < 14; i++) step();
    checks++;
    if (outs !== OutErr || stall_cnt_o !== 4'd15) begin
      errors++;
      $display("FAIL timeout_sat: got %b cnt %0d want %b cnt 15", outs, stall_cnt_o, OutErr);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (outs !== OutTo) begin
      errors++;
      $display("FAIL timeout_rst_comb: got %b want %b", outs, OutTo);
    end
    step();
    rst_i = 1'b0;
    EXMEM_MemRead_i = 1'b1;
    #1;
    checks++;
    if (outs !== OutFull || stall_cnt_o !== 4'd0) begin
      errors++;
      $display("FAIL timeout_rst: got %b cnt %0d want %b cnt 0", outs, stall_cnt_o, OutFull);
    end
    step();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_lu_branch();
    test_mem_wait();
    test_mem_overlap();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
